// File: rtl/vga_frame_sync_if.sv
// vga_frame_sync_if: raster coordinates, mux colour input and VGA DAC/sync outputs
interface vga_frame_sync_if;
    logic [7:0]  RGBIn;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        startOfFrame;
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;
    logic        hSync;
    logic        vSync;
    logic        blankN;
    modport master (
        input  RGBIn,
        output pixelX, pixelY, startOfFrame, red, green, blue, hSync, vSync, blankN
    );
    modport slave (
        output RGBIn,
        input  pixelX, pixelY, startOfFrame, red, green, blue, hSync, vSync, blankN
    );
endinterface

// File: rtl/vga_frame_sync.sv
// vga_frame_sync: raster counters plus sync/blank delayed to line up with the mux RGB, expanded for the DAC
module vga_frame_sync #(
    parameter int   H_ACTIVE   = 640,
    parameter int   H_FP       = 16,
    parameter int   H_SYNC     = 96,
    parameter int   H_BP       = 48,
    parameter int   V_ACTIVE   = 480,
    parameter int   V_FP       = 10,
    parameter int   V_SYNC     = 2,
    parameter int   V_BP       = 33,
    parameter logic SYNC_POL   = 1'b0,
    parameter int   PIPE_DELAY = 1
) (
    input logic              clk,
    input logic              resetN,
    vga_frame_sync_if.master vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    logic [10:0]           h_count, v_count;
    logic                  run, sof, h_last, v_last, active, hs, vs;
    logic [PIPE_DELAY-1:0] act_d, hs_d, vs_d;
    logic [2:0]            r, g;
    logic [1:0]            b;
    // run is low for the first edge after reset so the scan starts at (0,0) with a startOfFrame pulse
    always_comb begin
        h_last = h_count == 11'(H_TOTAL - 1);
        v_last = v_count == 11'(V_TOTAL - 1);
        active = run && h_count < 11'(H_ACTIVE) && v_count < 11'(V_ACTIVE);
        hs     = run && h_count >= 11'(H_ACTIVE + H_FP) && h_count < 11'(H_ACTIVE + H_FP + H_SYNC);
        vs     = run && v_count >= 11'(V_ACTIVE + V_FP) && v_count < 11'(V_ACTIVE + V_FP + V_SYNC);
        {r, g, b} = vga.RGBIn;
    end
    always_ff @(posedge clk or negedge resetN)
        if (!resetN) begin
            h_count <= '0;
            v_count <= '0;
            run     <= 1'b0;
            sof     <= 1'b0;
        end else begin
            run <= 1'b1;
            sof <= run ? h_last && v_last : 1'b1;
            if (run) begin
                h_count <= h_last ? '0 : h_count + 11'd1;
                if (h_last)
                    v_count <= v_last ? '0 : v_count + 11'd1;
            end
        end
    // raw timing flags ride alongside the upstream mux latency, then register with its RGB
    always_ff @(posedge clk or negedge resetN)
        if (!resetN) begin
            act_d      <= '0;
            hs_d       <= '0;
            vs_d       <= '0;
            vga.red    <= '0;
            vga.green  <= '0;
            vga.blue   <= '0;
            vga.hSync  <= ~SYNC_POL;
            vga.vSync  <= ~SYNC_POL;
            vga.blankN <= 1'b0;
        end else begin
            act_d      <= (act_d << 1) | PIPE_DELAY'(active);
            hs_d       <= (hs_d << 1) | PIPE_DELAY'(hs);
            vs_d       <= (vs_d << 1) | PIPE_DELAY'(vs);
            vga.red    <= act_d[PIPE_DELAY-1] ? {r, r, r[2:1]} : 8'd0;
            vga.green  <= act_d[PIPE_DELAY-1] ? {g, g, g[2:1]} : 8'd0;
            vga.blue   <= act_d[PIPE_DELAY-1] ? {b, b, b, b} : 8'd0;
            vga.hSync  <= hs_d[PIPE_DELAY-1] ? SYNC_POL : ~SYNC_POL;
            vga.vSync  <= vs_d[PIPE_DELAY-1] ? SYNC_POL : ~SYNC_POL;
            vga.blankN <= act_d[PIPE_DELAY-1];
        end
    assign vga.pixelX       = h_count;
    assign vga.pixelY       = v_count;
    assign vga.startOfFrame = sof;
endmodule

// File: tb/tb_vga_frame_sync.sv
// tb_vga_frame_sync: full-size instance (delay 1) and shrunken-frame instance (delay 3) against a cycle model
module tb_vga_frame_sync;
    typedef struct {
        bit         v;
        int         x;
        int         y;
        logic [7:0] rgb;
    } ent_t;
    logic clk = 1'b0;
    logic resetN = 1'b1;
    vga_frame_sync_if ia ();
    vga_frame_sync_if ib ();
    vga_frame_sync dut_a (.clk(clk), .resetN(resetN), .vga(ia));
    vga_frame_sync #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .SYNC_POL(1'b0), .PIPE_DELAY(3)
    ) dut_b (.clk(clk), .resetN(resetN), .vga(ib));
    always #5 clk = ~clk;
    int   errs = 0, checks = 0, c = 0, t = 0, mode = 0;
    bit   run_m = 0, trk = 0;
    ent_t ra[8], rb[8];
    int   a_hs_fall = -1, a_hs_cnt = 0, a_bn_rise = -1, a_bn_fall = -1;
    int   b_vs_fall = -1, b_vs_cnt = 0, b_ymax = 0;
    int   b_sof[$];
    // mode 0: random mux colour; mode 1: left half 0xE0, right half 0x03, blanking 0xFF
    function automatic ent_t mk(bit v, int tt, int ht, int vt, int ha, int va);
        ent_t e;
        e.v   = v;
        e.x   = v ? tt % ht : 0;
        e.y   = v ? (tt / ht) % vt : 0;
        e.rgb = mode == 0 ? 8'($urandom) :
                (v && e.x < ha && e.y < va) ? (e.x < ha / 2 ? 8'hE0 : 8'h03) : 8'hFF;
        return e;
    endfunction
    function automatic logic [49:0] exp_vec(ent_t p, ent_t o, bit sof, int ha, int hf, int hw, int va, int vf, int vw);
        bit         act, hsy, vsy;
        logic [2:0] r, g;
        act = o.v && o.x < ha && o.y < va;
        hsy = o.v && o.x >= ha + hf && o.x < ha + hf + hw;
        vsy = o.v && o.y >= va + vf && o.y < va + vf + vw;
        r   = o.rgb[7:5];
        g   = o.rgb[4:2];
        return {11'(p.x), 11'(p.y), sof,
                act ? 8'(r * 36 + r / 2) : 8'd0,
                act ? 8'(g * 36 + g / 2) : 8'd0,
                act ? 8'(o.rgb[1:0] * 85) : 8'd0,
                ~hsy, ~vsy, act};
    endfunction
    task automatic chk(string tag, logic [63:0] got, logic [63:0] want);
        checks++;
        assert (got === want) else begin
            errs++;
            $error("FAIL %s t=%0d got=%h want=%h", tag, t, got, want);
        end
    endtask
    task automatic check();
        chk("a_out", {ia.pixelX, ia.pixelY, ia.startOfFrame, ia.red, ia.green, ia.blue, ia.hSync, ia.vSync, ia.blankN},
            exp_vec(ra[c % 8], ra[(c + 6) % 8], run_m && t % 420000 == 0, 640, 16, 96, 480, 10, 2));
        chk("b_out", {ib.pixelX, ib.pixelY, ib.startOfFrame, ib.red, ib.green, ib.blue, ib.hSync, ib.vSync, ib.blankN},
            exp_vec(rb[c % 8], rb[(c + 4) % 8], run_m && t % 384 == 0, 16, 2, 3, 10, 2, 2));
    endtask
    task automatic step();
        @(posedge clk);
        if (resetN) begin
            if (run_m) t++;
            else begin
                run_m = 1;
                t = 0;
            end
        end
        #1;
        c++;
        ra[c % 8] = mk(run_m, t, 800, 525, 640, 480);
        rb[c % 8] = mk(run_m, t, 24, 16, 16, 10);
        check();
        ia.RGBIn = ra[(c + 7) % 8].rgb;
        ib.RGBIn = rb[(c + 5) % 8].rgb;
        if (trk && run_m) begin
            if (!ia.hSync && a_hs_fall < 0) a_hs_fall = t;
            if (!ia.hSync && t <= 801) a_hs_cnt++;
            if (ia.blankN && a_bn_rise < 0) a_bn_rise = t;
            if (!ia.blankN && a_bn_rise >= 0 && a_bn_fall < 0) a_bn_fall = t;
            if (ib.startOfFrame) b_sof.push_back(t);
            if (!ib.vSync && b_vs_fall < 0) b_vs_fall = t;
            if (!ib.vSync && t < 388) b_vs_cnt++;
            if (int'(ib.pixelY) > b_ymax) b_ymax = int'(ib.pixelY);
        end
    endtask
    task automatic do_reset(int n);
        resetN = 1'b0;
        run_m  = 0;
        for (int i = 0; i < 8; i++) begin
            ra[i] = mk(0, 0, 800, 525, 640, 480);
            rb[i] = mk(0, 0, 24, 16, 16, 10);
        end
        #1;
        check();
        repeat (n) step();
        resetN = 1'b1;
    endtask
    initial begin
        ia.RGBIn = 8'h00;
        ib.RGBIn = 8'h00;
        #2;
        do_reset(3);
        trk = 1;
        step();
        chk("first_pix", {ia.pixelX, ia.pixelY, ia.startOfFrame, ia.hSync, ia.vSync, ia.blankN}, {11'd0, 11'd0, 4'b1110});
        repeat (1799) step();
        trk = 0;
        chk("a_hs_fall", a_hs_fall, 658);
        chk("a_hs_width", a_hs_cnt, 96);
        chk("a_bn_rise", a_bn_rise, 2);
        chk("a_bn_fall", a_bn_fall, 642);
        chk("b_sof_cnt", b_sof.size() >= 2, 1);
        if (b_sof.size() >= 2) begin
            chk("b_sof0", b_sof[0], 0);
            chk("b_sof_period", b_sof[1] - b_sof[0], 384);
        end
        chk("b_vs_fall", b_vs_fall, 292);
        chk("b_vs_width", b_vs_cnt, 48);
        chk("b_ymax", b_ymax, 15);
        for (int i = 0; i < 400 && t % 384 != 130; i++) step();
        chk("mid_frame_hit", t % 384, 130);
        do_reset(3);
        mode = 1;
        step();
        chk("restart", {ia.pixelX, ia.pixelY, ia.startOfFrame, ib.pixelX, ib.pixelY, ib.startOfFrame},
            {11'd0, 11'd0, 1'b1, 11'd0, 11'd0, 1'b1});
        repeat (900) begin
            step();
            if (t == 102) chk("rgb_e0", {ia.red, ia.green, ia.blue, ia.blankN}, {24'hFF0000, 1'b1});
            if (t == 402) chk("rgb_03", {ia.red, ia.green, ia.blue, ia.blankN}, {24'h0000FF, 1'b1});
            if (t == 702) chk("rgb_blank", {ia.red, ia.green, ia.blue, ia.blankN}, {24'h000000, 1'b0});
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
